// File: rtl/ysyx_22041071_wb_arb_if.sv
// Write-back arbiter bus bundle.
// Groups the pipeline WB request, the multi-cycle completion request,
// the scoreboard issue/busy signals, the regfile write port, the difftest
// commit stream, the sticky error flag and two debug views of internal state.
//
// Handshake: a requester raises *_valid and holds every payload field stable
// until it samples *_ready high in the same cycle; a transfer happens exactly
// in a cycle where valid and ready are both 1. Ready may depend
// combinationally on valid and never feeds back into it.
//
// Modports:
//   slave  - the arbiter side (takes requests, drives readies and results)
//   master - the environment side (pipeline / mul-div / scoreboard / observers)
interface ysyx_22041071_wb_arb_if;
  // pipeline WB request
  logic        p_valid;
  logic [63:0] p_pc;
  logic [31:0] p_ins;
  logic        p_wen;
  logic [4:0]  p_rd;
  logic [63:0] p_data;
  logic        p_ready;
  // multi-cycle completion request
  logic        m_valid;
  logic [63:0] m_pc;
  logic [31:0] m_ins;
  logic [4:0]  m_rd;
  logic [63:0] m_data;
  logic        m_ready;
  // scoreboard issue and busy view
  logic        sb_set;
  logic [4:0]  sb_rd;
  logic [31:0] sb_busy;
  // regfile write port
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  // difftest commit stream
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic [31:0] commit_ins;
  logic        commit_src;
  // sticky illegal-issue flag
  logic        err;
  // debug: WAW kill vector and contention pointer (1 = m won last contention)
  logic [31:0] dbg_kill;
  logic        dbg_last_grant;

  modport slave (
    input  p_valid, p_pc, p_ins, p_wen, p_rd, p_data,
    input  m_valid, m_pc, m_ins, m_rd, m_data,
    input  sb_set, sb_rd,
    output p_ready, m_ready, sb_busy,
    output rf_wen, rf_waddr, rf_wdata,
    output commit_valid, commit_pc, commit_ins, commit_src,
    output err, dbg_kill, dbg_last_grant
  );

  modport master (
    output p_valid, p_pc, p_ins, p_wen, p_rd, p_data,
    output m_valid, m_pc, m_ins, m_rd, m_data,
    output sb_set, sb_rd,
    input  p_ready, m_ready, sb_busy,
    input  rf_wen, rf_waddr, rf_wdata,
    input  commit_valid, commit_pc, commit_ins, commit_src,
    input  err, dbg_kill, dbg_last_grant
  );
endinterface

// File: rtl/ysyx_22041071_wb_arb.sv
// Write-back arbiter: merges the in-order pipeline write-back and the
// out-of-order multi-cycle (mul/div) completions onto one regfile write port
// and one difftest commit stream, one transfer per cycle.
// A busy scoreboard tracks registers with a pending multi-cycle write; a kill
// vector suppresses a stale multi-cycle write when a younger pipeline write
// to the same register has already retired (WAW).
//
// Ports:
//   clk   - clock, all state on rising edge
//   reset - synchronous active-low reset
//   bus   - ysyx_22041071_wb_arb_if.slave (requests, readies, rf/commit
//           outputs, sb_busy, err, debug state)
module ysyx_22041071_wb_arb (
  input  logic                    clk,
  input  logic                    reset,
  ysyx_22041071_wb_arb_if.slave   bus
);

  logic        rf_wen_q,       rf_wen_d;
  logic [4:0]  rf_waddr_q,     rf_waddr_d;
  logic [63:0] rf_wdata_q,     rf_wdata_d;
  logic        commit_valid_q, commit_valid_d;
  logic [63:0] commit_pc_q,    commit_pc_d;
  logic [31:0] commit_ins_q,   commit_ins_d;
  logic        commit_src_q,   commit_src_d;
  logic [31:0] sb_busy_q,      sb_busy_d;
  logic [31:0] kill_q,         kill_d;
  logic        err_q,          err_d;
  // 1 = m won the last contended cycle; reset to 0 so m wins the first one
  logic        last_grant_q,   last_grant_d;

  logic contended;
  logic grant_p;
  logic grant_m;

  assign contended = bus.p_valid & bus.m_valid;
  // Readies are forced low while in reset so nothing is accepted then.
  assign grant_m = reset & bus.m_valid & (~bus.p_valid | ~last_grant_q);
  assign grant_p = reset & bus.p_valid & (~bus.m_valid | last_grant_q);

  assign bus.p_ready        = grant_p;
  assign bus.m_ready        = grant_m;
  assign bus.rf_wen         = rf_wen_q;
  assign bus.rf_waddr       = rf_waddr_q;
  assign bus.rf_wdata       = rf_wdata_q;
  assign bus.commit_valid   = commit_valid_q;
  assign bus.commit_pc      = commit_pc_q;
  assign bus.commit_ins     = commit_ins_q;
  assign bus.commit_src     = commit_src_q;
  assign bus.sb_busy        = sb_busy_q;
  assign bus.err            = err_q;
  assign bus.dbg_kill       = kill_q;
  assign bus.dbg_last_grant = last_grant_q;

  always_comb begin
    rf_wen_d       = 1'b0;
    rf_waddr_d     = rf_waddr_q;
    rf_wdata_d     = rf_wdata_q;
    commit_valid_d = 1'b0;
    commit_pc_d    = commit_pc_q;
    commit_ins_d   = commit_ins_q;
    commit_src_d   = commit_src_q;
    sb_busy_d      = sb_busy_q;
    kill_d         = kill_q;
    err_d          = err_q;
    last_grant_d   = contended ? grant_m : last_grant_q;

    if (grant_p) begin
      rf_wen_d       = bus.p_wen & (bus.p_rd != 5'd0);
      rf_waddr_d     = bus.p_rd;
      rf_wdata_d     = bus.p_data;
      commit_valid_d = 1'b1;
      commit_pc_d    = bus.p_pc;
      commit_ins_d   = bus.p_ins;
      commit_src_d   = 1'b0;
      // Younger pipeline write retires ahead of a pending multi-cycle write.
      if (bus.p_wen && (bus.p_rd != 5'd0) && sb_busy_q[bus.p_rd])
        kill_d[bus.p_rd] = 1'b1;
    end else if (grant_m) begin
      rf_wen_d       = (bus.m_rd != 5'd0) & ~kill_q[bus.m_rd];
      rf_waddr_d     = bus.m_rd;
      rf_wdata_d     = bus.m_data;
      commit_valid_d = 1'b1;
      commit_pc_d    = bus.m_pc;
      commit_ins_d   = bus.m_ins;
      commit_src_d   = 1'b1;
      sb_busy_d[bus.m_rd] = 1'b0;
      kill_d[bus.m_rd]    = 1'b0;
    end

    // Issue applied after completion so a same-cycle set wins over the clear.
    if (bus.sb_set && (bus.sb_rd != 5'd0)) begin
      if (sb_busy_q[bus.sb_rd] && !(grant_m && (bus.m_rd == bus.sb_rd)))
        err_d = 1'b1;
      sb_busy_d[bus.sb_rd] = 1'b1;
    end

    sb_busy_d[0] = 1'b0;
    kill_d[0]    = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_wen_q       <= 1'b0;
      rf_waddr_q     <= 5'd0;
      rf_wdata_q     <= 64'd0;
      commit_valid_q <= 1'b0;
      commit_pc_q    <= 64'd0;
      commit_ins_q   <= 32'd0;
      commit_src_q   <= 1'b0;
      sb_busy_q      <= 32'd0;
      kill_q         <= 32'd0;
      err_q          <= 1'b0;
      last_grant_q   <= 1'b0;
    end else begin
      rf_wen_q       <= rf_wen_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      commit_valid_q <= commit_valid_d;
      commit_pc_q    <= commit_pc_d;
      commit_ins_q   <= commit_ins_d;
      commit_src_q   <= commit_src_d;
      sb_busy_q      <= sb_busy_d;
      kill_q         <= kill_d;
      err_q          <= err_d;
      last_grant_q   <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22041071_wb_arb.sv
module tb_ysyx_22041071_wb_arb;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [63:0] exp_q[$];

  ysyx_22041071_wb_arb_if bus();

  ysyx_22041071_wb_arb dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.p_valid = 1'b0; bus.p_pc = '0; bus.p_ins = '0; bus.p_wen = 1'b0;
    bus.p_rd = '0; bus.p_data = '0;
    bus.m_valid = 1'b0; bus.m_pc = '0; bus.m_ins = '0; bus.m_rd = '0;
    bus.m_data = '0;
    bus.sb_set = 1'b0; bus.sb_rd = '0;
  endtask

  task automatic drive_p(input logic [63:0] pc, input logic [31:0] ins,
                         input logic wen, input logic [4:0] rd, input logic [63:0] data);
    bus.p_valid = 1'b1; bus.p_pc = pc; bus.p_ins = ins; bus.p_wen = wen;
    bus.p_rd = rd; bus.p_data = data;
  endtask

  task automatic drive_m(input logic [63:0] pc, input logic [31:0] ins,
                         input logic [4:0] rd, input logic [63:0] data);
    bus.m_valid = 1'b1; bus.m_pc = pc; bus.m_ins = ins; bus.m_rd = rd;
    bus.m_data = data;
  endtask

  task automatic check_commit_pc_from_queue();
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      check("commit_q_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("contend_pc", bus.commit_pc, e);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    idle();
    step();
    step();

    // readies held low during reset even with both requesting
    drive_p(64'h10, 32'h1, 1'b1, 5'd1, 64'h1);
    drive_m(64'h20, 32'h2, 5'd2, 64'h2);
    #1;
    check("rst_p_ready", bus.p_ready, 0);
    check("rst_m_ready", bus.m_ready, 0);
    step();
    check("rst_rf_wen", bus.rf_wen, 0);
    check("rst_commit_valid", bus.commit_valid, 0);
    check("rst_commit_pc", bus.commit_pc, 0);
    check("rst_sb_busy", bus.sb_busy, 0);
    check("rst_err", bus.err, 0);
    check("rst_last_grant", bus.dbg_last_grant, 0);

    idle();
    reset = 1'b1;
    step();
    check("post_rst_rf_wen", bus.rf_wen, 0);
    check("post_rst_commit_valid", bus.commit_valid, 0);

    // single pipeline write
    drive_p(64'h8000_0000, 32'h13, 1'b1, 5'd5, 64'h1234);
    #1;
    check("single_p_ready", bus.p_ready, 1);
    check("single_m_ready", bus.m_ready, 0);
    step();
    check("single_rf_wen", bus.rf_wen, 1);
    check("single_rf_waddr", bus.rf_waddr, 5);
    check("single_rf_wdata", bus.rf_wdata, 64'h1234);
    check("single_commit_valid", bus.commit_valid, 1);
    check("single_commit_src", bus.commit_src, 0);
    check("single_commit_pc", bus.commit_pc, 64'h8000_0000);
    check("single_commit_ins", bus.commit_ins, 32'h13);
    idle();
    step();
    check("idle_rf_wen", bus.rf_wen, 0);
    check("idle_commit_valid", bus.commit_valid, 0);
    check("idle_waddr_hold", bus.rf_waddr, 5);
    check("idle_pc_hold", bus.commit_pc, 64'h8000_0000);

    // contention: m, p, m, then p alone; every p transfer commits once
    exp_q.push_back(64'h200);
    exp_q.push_back(64'h100);
    exp_q.push_back(64'h204);
    exp_q.push_back(64'h104);
    drive_p(64'h100, 32'h11, 1'b1, 5'd3, 64'h333);
    drive_m(64'h200, 32'h22, 5'd4, 64'h444);
    #1;
    check("cont1_m_ready", bus.m_ready, 1);
    check("cont1_p_ready", bus.p_ready, 0);
    step();
    check_commit_pc_from_queue();
    check("cont1_src", bus.commit_src, 1);
    check("cont1_wdata", bus.rf_wdata, 64'h444);
    drive_m(64'h204, 32'h23, 5'd4, 64'h445);
    #1;
    check("cont2_p_ready", bus.p_ready, 1);
    check("cont2_m_ready", bus.m_ready, 0);
    step();
    check_commit_pc_from_queue();
    check("cont2_src", bus.commit_src, 0);
    check("cont2_waddr", bus.rf_waddr, 3);
    check("cont2_wdata", bus.rf_wdata, 64'h333);
    drive_p(64'h104, 32'h12, 1'b1, 5'd3, 64'h334);
    #1;
    check("cont3_m_ready", bus.m_ready, 1);
    check("cont3_p_ready", bus.p_ready, 0);
    step();
    check_commit_pc_from_queue();
    check("cont3_wdata", bus.rf_wdata, 64'h445);
    bus.m_valid = 1'b0;
    #1;
    check("cont4_p_ready", bus.p_ready, 1);
    step();
    check_commit_pc_from_queue();
    check("cont4_src", bus.commit_src, 0);
    idle();
    step();
    check("cont_no_dup", bus.commit_valid, 0);
    check("cont_q_drained", exp_q.size(), 0);

    // WAW: younger pipeline write kills the multi-cycle write
    bus.sb_set = 1'b1; bus.sb_rd = 5'd7;
    step();
    bus.sb_set = 1'b0;
    check("waw_busy_set", bus.sb_busy, 32'h80);
    drive_p(64'h300, 32'h30, 1'b1, 5'd7, 64'hA);
    step();
    bus.p_valid = 1'b0;
    check("waw_p_wen", bus.rf_wen, 1);
    check("waw_p_waddr", bus.rf_waddr, 7);
    check("waw_p_wdata", bus.rf_wdata, 64'hA);
    check("waw_kill_set", bus.dbg_kill, 32'h80);
    drive_m(64'h400, 32'h40, 5'd7, 64'hB);
    #1;
    check("waw_m_ready", bus.m_ready, 1);
    step();
    bus.m_valid = 1'b0;
    check("waw_m_commit", bus.commit_valid, 1);
    check("waw_m_src", bus.commit_src, 1);
    check("waw_m_pc", bus.commit_pc, 64'h400);
    check("waw_m_rf_wen", bus.rf_wen, 0);
    check("waw_busy_clr", bus.sb_busy, 0);
    check("waw_kill_clr", bus.dbg_kill, 0);

    // same-cycle set and completion, then illegal re-issue
    bus.sb_set = 1'b1; bus.sb_rd = 5'd9;
    step();
    check("same_busy_pre", bus.sb_busy, 32'h200);
    drive_m(64'h500, 32'h50, 5'd9, 64'h99);
    step();
    bus.m_valid = 1'b0;
    check("same_busy_kept", bus.sb_busy, 32'h200);
    check("same_err0", bus.err, 0);
    check("same_kill0", bus.dbg_kill, 0);
    check("same_m_rf_wen", bus.rf_wen, 1);
    step();
    check("reissue_err", bus.err, 1);
    bus.sb_set = 1'b0;
    step();
    check("err_sticky", bus.err, 1);

    // rd=0 and p_wen=0 commit without writing
    drive_p(64'h600, 32'h60, 1'b1, 5'd0, 64'hFF);
    step();
    bus.p_valid = 1'b0;
    check("rd0_commit", bus.commit_valid, 1);
    check("rd0_rf_wen", bus.rf_wen, 0);
    bus.sb_set = 1'b1; bus.sb_rd = 5'd0;
    step();
    bus.sb_set = 1'b0;
    check("rd0_sb_busy", bus.sb_busy, 32'h200);
    drive_p(64'h700, 32'h70, 1'b0, 5'd6, 64'h66);
    step();
    bus.p_valid = 1'b0;
    check("wen0_commit", bus.commit_valid, 1);
    check("wen0_rf_wen", bus.rf_wen, 0);

    // pointer persists (m won last contention), then reset mid-contention
    drive_p(64'h800, 32'h80, 1'b1, 5'd2, 64'h22);
    drive_m(64'h900, 32'h90, 5'd3, 64'h33);
    #1;
    check("ptr_p_ready", bus.p_ready, 1);
    check("ptr_m_ready", bus.m_ready, 0);
    step();
    check("ptr_commit_pc", bus.commit_pc, 64'h800);
    reset = 1'b0;
    #1;
    check("mid_rst_p_ready", bus.p_ready, 0);
    check("mid_rst_m_ready", bus.m_ready, 0);
    step();
    check("mid_rst_rf_wen", bus.rf_wen, 0);
    check("mid_rst_waddr", bus.rf_waddr, 0);
    check("mid_rst_wdata", bus.rf_wdata, 0);
    check("mid_rst_commit_valid", bus.commit_valid, 0);
    check("mid_rst_commit_pc", bus.commit_pc, 0);
    check("mid_rst_commit_ins", bus.commit_ins, 0);
    check("mid_rst_sb_busy", bus.sb_busy, 0);
    check("mid_rst_err", bus.err, 0);
    check("mid_rst_kill", bus.dbg_kill, 0);
    reset = 1'b1;
    #1;
    check("after_rst_m_ready", bus.m_ready, 1);
    check("after_rst_p_ready", bus.p_ready, 0);
    step();
    check("after_rst_pc", bus.commit_pc, 64'h900);
    check("after_rst_src", bus.commit_src, 1);
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
